// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first subtractor computing D = A - B - Bin.
// One full-subtractor cell and a borrow flip-flop process one bit per clock;
// an operation occupies WIDTH+2 cycles (IDLE accept, WIDTH SHIFT, DONE).
// Optional macro SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output V.
//
// Handshake: start is a request sampled only while the block is IDLE (busy=0);
// the edge that samples start=1 captures A, B and Bin, after which they may
// change freely. busy is high through SHIFT and DONE, and start is ignored
// while busy is high (no queueing). done is a one-cycle pulse in the DONE
// state; D/Bout (and V) are valid from that pulse and hold until the next
// completion or a reset.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic [1:0]       o_dbg_state,
  output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_a;
  logic             w_b;
  logic             w_diff;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_accept    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_DONE;
          w_last      = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs plus the assembled result
  always_comb begin
    w_a          = r_a_sh[0];
    w_b          = r_b_sh[0];
    w_diff       = w_a ^ w_b ^ r_borrow;
    w_borrow_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    w_res_nxt    = {w_diff, r_res_sh[WIDTH-1:1]};
  end

  // Datapath: operand capture, bit shifting, result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a_sh   <= A;
        r_b_sh   <= B;
        r_borrow <= Bin;
        r_res_sh <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_SHIFT) begin
        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_res_sh <= w_res_nxt;
        r_borrow <= w_borrow_nxt;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_d    <= w_res_nxt;
          r_bout <= w_borrow_nxt;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_v;

  // Signed overflow: operand signs differ and result sign differs from A.
  // The result MSB is the bit produced on the last SHIFT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
      end
      if (w_last) r_v <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
    end
  end

  assign V = r_v;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign D           = r_d;
  assign Bout        = r_bout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): hand-computed vectors,
// immediate assertions at every comparison point, one summary line.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d_out;
  logic [1:0]   dbg_state;
  logic         bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         v_out;
`endif

  int total;
  int bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (a_in),
    .B           (b_in),
    .Bin         (bin_in),
    .busy        (busy),
    .done        (done),
    .D           (d_out),
    .o_dbg_state (dbg_state),
    .Bout        (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .V           (v_out)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation. Inputs are driven at negedges and outputs sampled there.
  // Cycle i is the cycle following the i-th edge after the accepting edge.
  // pulse_at: raise start for one edge in cycle i (0 = never).
  // rst_at:   raise rst for one edge in cycle i (0 = never).
  task automatic run_op(input string name,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] exp_d, input logic exp_bout, input logic exp_v,
                        input logic [W-1:0] prev_d, input int pulse_at, input int rst_at);
    int busy_cnt;
    int done_pos;
    int done_cnt;
    int exp_busy;
    int exp_done_pos;
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    bin_in = bi;
    start  = 1'b1;
    busy_cnt = 0;
    done_pos = 0;
    done_cnt = 0;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      start  = 1'b0;
      rst    = 1'b0;
      a_in   = W'($urandom_range(0, 255));
      b_in   = W'($urandom_range(0, 255));
      bin_in = 1'($urandom_range(0, 1));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_pos = i;
      end
      if ((i == 3 || i == W) && (rst_at == 0 || i <= rst_at))
        check({name, "_d_hold"}, 32'(d_out), 32'(prev_d));
      if (rst_at != 0 && i == rst_at + 1) begin
        check({name, "_rst_busy"}, 32'(busy), 32'd0);
        check({name, "_rst_d"}, 32'(d_out), 32'd0);
        check({name, "_rst_bout"}, 32'(bout), 32'd0);
      end
      if (i == pulse_at) start = 1'b1;
      if (i == rst_at) rst = 1'b1;
    end
    exp_busy     = (rst_at != 0) ? rst_at : W + 1;
    exp_done_pos = (rst_at != 0) ? 0 : W + 1;
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({name, "_done_pos"}, 32'(done_pos), 32'(exp_done_pos));
    check({name, "_done_count"}, 32'(done_cnt), (rst_at != 0) ? 32'd0 : 32'd1);
    check({name, "_d"}, 32'(d_out), 32'(exp_d));
    check({name, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({name, "_v"}, 32'(v_out), 32'(exp_v));
`else
    if (exp_v) $display("note: %s overflow expectation not applicable in this build", name);
`endif
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    bin_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_d", 32'(d_out), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    //      name         A      B      Bin   D      Bout  V     prevD  pulse rst
    run_op("sub_5_3",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 0, 0);
    run_op("sub_3_5",    8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 8'h02, 0, 0);
    run_op("sub_0_0_b",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFE, 0, 0);
    run_op("sub_eq",     8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 0, 0);
    run_op("full_wrap",  8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0);
    run_op("start_ign",  8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h00, 3, 0);
    run_op("sub_3_5b",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 8'h0F, 0, 0);
    run_op("mid_reset",  8'h44, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFE, 0, 4);
    run_op("after_rst",  8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 0, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op("ovf_80_01",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8'h10, 0, 0);
    run_op("ovf_7f_ff",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 8'h7F, 0, 0);
    run_op("novf_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h80, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "time limit reached");
  end

endmodule
